// File: rtl/dma_pkg.sv
// dma_pkg: shared types and constants for the DMA service sequencer.
//   NUM_CH  - number of DMA channels (only 4 is supported)
//   CH_W    - channel index width
//   state_t - sequencer states SI, S0..S4
//   onehot  - channel index to one-hot channel vector
package dma_pkg;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  typedef enum logic [2:0] {SI, S0, S1, S2, S3, S4} state_t;

  function automatic logic [NUM_CH-1:0] onehot(input logic [CH_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction
endpackage

// File: rtl/dma_priority_encoder.sv
// dma_priority_encoder: combinational channel arbiter.
//   req_i - eligible requests
//   ptr_i - channel that currently has highest priority (0 = fixed priority)
//   win_o - winning channel index
//   vld_o - at least one request present
module dma_priority_encoder
  import dma_pkg::*;
(
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   ptr_i,
  output logic [CH_W-1:0]   win_o,
  output logic              vld_o
);
  logic [CH_W-1:0] idx;

  // Scan from the pointer upwards; CH_W-bit addition wraps around the ring.
  always_comb begin
    win_o = '0;
    vld_o = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = ptr_i + CH_W'(i);
      if (!vld_o && req_i[idx]) begin
        vld_o = 1'b1;
        win_o = idx;
      end
    end
  end
endmodule

// File: rtl/dma_service_sequencer.sv
// dma_service_sequencer: timing-and-control core of a 4-channel DMA controller.
// Arbitrates DREQ, requests the bus (HRQ/HLDA) and runs one single-mode
// transfer per grant: S1 DACK/AEN/ADSTB, S2 read strobe, S3 read+write
// strobes, S4 xferDone and terminal-count sampling.
// Ports:
//   CLK, RESET (sync, active-high)
//   DREQ, chMask, xferWrite, tcClear - per-channel inputs
//   HLDA, tcIn                       - hold acknowledge, terminal count
//   HRQ, DACK, AEN, ADSTB            - bus request / acknowledge / address
//   IOR_N, IOW_N, MEMR_N, MEMW_N     - active-low strobes
//   activeCh, xferDone, tcStatus     - serviced channel, done pulse, TC flags
// Build option: ROTATING_PRIORITY_EN makes the serviced channel lowest
// priority after each completed transfer; otherwise priority is fixed.
module dma_service_sequencer
  import dma_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic [NUM_CH-1:0] chMask,
  input  logic [NUM_CH-1:0] xferWrite,
  input  logic              HLDA,
  input  logic              tcIn,
  input  logic [NUM_CH-1:0] tcClear,
  output logic              HRQ,
  output logic [NUM_CH-1:0] DACK,
  output logic              AEN,
  output logic              ADSTB,
  output logic              IOR_N,
  output logic              IOW_N,
  output logic              MEMR_N,
  output logic              MEMW_N,
  output logic [CH_W-1:0]   activeCh,
  output logic              xferDone,
  output logic [NUM_CH-1:0] tcStatus
);
  state_t            state_q;
  logic              hrq_q, aen_q, adstb_q, done_q, dir_q;
  logic              ior_q, iow_q, memr_q, memw_q;
  logic [NUM_CH-1:0] dack_q, tc_q, req, tc_set;
  logic [CH_W-1:0]   ch_q, ptr, win;
  logic              win_vld;

  assign req    = DREQ & ~chMask;
  assign tc_set = (state_q == S4 && tcIn) ? onehot(ch_q) : '0;

`ifdef ROTATING_PRIORITY_EN
  logic [CH_W-1:0] ptr_q;
  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  dma_priority_encoder u_prio (
    .req_i (req),
    .ptr_i (ptr),
    .win_o (win),
    .vld_o (win_vld)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= SI;
      hrq_q   <= 1'b0;
      dack_q  <= '0;
      aen_q   <= 1'b0;
      adstb_q <= 1'b0;
      ior_q   <= 1'b1;
      iow_q   <= 1'b1;
      memr_q  <= 1'b1;
      memw_q  <= 1'b1;
      ch_q    <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
      tc_q    <= '0;
`ifdef ROTATING_PRIORITY_EN
      ptr_q   <= '0;
`endif
    end else begin
      // Set wins over a coincident clear.
      tc_q <= (tc_q & ~tcClear) | tc_set;
      case (state_q)
        SI: if (|req) begin
          state_q <= S0;
          hrq_q   <= 1'b1;
        end
        S0: if (~|req) begin
          state_q <= SI;
          hrq_q   <= 1'b0;
        end else if (HLDA && win_vld) begin
          // Arbitration is resolved here, in the HLDA cycle; direction is
          // latched so the strobe pair cannot change mid-transfer.
          state_q <= S1;
          ch_q    <= win;
          dir_q   <= xferWrite[win];
          dack_q  <= onehot(win);
          aen_q   <= 1'b1;
          adstb_q <= 1'b1;
        end
        S1, S2, S3: if (!HLDA) begin
          // Lost the bus: back off cleanly, no done pulse, no TC update.
          state_q <= SI;
          hrq_q   <= 1'b0;
          dack_q  <= '0;
          aen_q   <= 1'b0;
          adstb_q <= 1'b0;
          ior_q   <= 1'b1;
          iow_q   <= 1'b1;
          memr_q  <= 1'b1;
          memw_q  <= 1'b1;
        end else if (state_q == S1) begin
          state_q <= S2;
          adstb_q <= 1'b0;
          if (dir_q) ior_q  <= 1'b0;
          else       memr_q <= 1'b0;
        end else if (state_q == S2) begin
          state_q <= S3;
          if (dir_q) memw_q <= 1'b0;
          else       iow_q  <= 1'b0;
        end else begin
          state_q <= S4;
          ior_q   <= 1'b1;
          iow_q   <= 1'b1;
          memr_q  <= 1'b1;
          memw_q  <= 1'b1;
          done_q  <= 1'b1;
        end
        S4: begin
          state_q <= SI;
          hrq_q   <= 1'b0;
          dack_q  <= '0;
          aen_q   <= 1'b0;
          done_q  <= 1'b0;
`ifdef ROTATING_PRIORITY_EN
          ptr_q   <= ch_q + 1'b1;
`endif
        end
        default: state_q <= SI;
      endcase
    end
  end

  assign HRQ      = hrq_q;
  assign DACK     = dack_q;
  assign AEN      = aen_q;
  assign ADSTB    = adstb_q;
  assign IOR_N    = ior_q;
  assign IOW_N    = iow_q;
  assign MEMR_N   = memr_q;
  assign MEMW_N   = memw_q;
  assign activeCh = ch_q;
  assign xferDone = done_q;
  assign tcStatus = tc_q;
endmodule
